// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

  localparam int BOOTH_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth recoding of {Q[0], q_m1}
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: conditional add/subtract of M,
// then arithmetic right shift of {A, Q, q_m1}.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic signed [WIDTH:0]   a,
  input  logic        [WIDTH-1:0] q,
  input  logic                    q_m1,
  input  logic signed [WIDTH-1:0] m,
  output logic signed [WIDTH:0]   a_nxt,
  output logic        [WIDTH-1:0] q_nxt,
  output logic                    q_m1_nxt
);

  logic signed [WIDTH:0] m_ext;
  logic signed [WIDTH:0] sum;

  assign m_ext = {m[WIDTH-1], m};

  always_comb begin
    sum = a;
    case ({q[0], q_m1})
      BOOTH_ADD: sum = a + m_ext;
      BOOTH_SUB: sum = a - m_ext;
      default:   sum = a;
    endcase
  end

  assign a_nxt    = {sum[WIDTH], sum[WIDTH:1]};
  assign q_nxt    = {sum[0], q[WIDTH-1:1]};
  assign q_m1_nxt = q[0];

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier with start/busy/done handshake.
// Optional BOOTH_ZERO_SKIP_EN: zero operands bypass iteration and finish in one clock.
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic signed [WIDTH-1:0]   multiplicand,
  input  logic signed [WIDTH-1:0]   multiplier,
  output logic                      busy,
  output logic                      done,
  output logic signed [2*WIDTH-1:0] product
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t state, state_nxt;

  logic signed [WIDTH:0]   a_reg;
  logic        [WIDTH-1:0] q_reg;
  logic signed [WIDTH-1:0] m_reg;
  logic                    q_m1;
  logic        [CNT_W-1:0] count;

  logic signed [WIDTH:0]   a_nxt;
  logic        [WIDTH-1:0] q_nxt;
  logic                    q_m1_nxt;
  logic                    zero_ops;
  logic                    last_iter;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a        (a_reg),
    .q        (q_reg),
    .q_m1     (q_m1),
    .m        (m_reg),
    .a_nxt    (a_nxt),
    .q_nxt    (q_nxt),
    .q_m1_nxt (q_m1_nxt)
  );

`ifdef BOOTH_ZERO_SKIP_EN
  assign zero_ops = (multiplicand == '0) || (multiplier == '0);
`else
  assign zero_ops = 1'b0;
`endif

  assign last_iter = (count == LAST_ITER);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = zero_ops ? DONE : RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_reg   <= '0;
      q_reg   <= '0;
      m_reg   <= '0;
      q_m1    <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= multiplicand;
            a_reg <= '0;
            q_reg <= multiplier;
            q_m1  <= 1'b0;
            count <= '0;
            if (zero_ops) product <= '0;
          end
        end
        RUN: begin
          a_reg <= a_nxt;
          q_reg <= q_nxt;
          q_m1  <= q_m1_nxt;
          count <= count + 1'b1;
          // final iteration result goes straight into the product register
          if (last_iter) product <= {a_nxt[WIDTH-1:0], q_nxt};
        end
        default: ;
      endcase
    end
  end

  // Decoded from the state register, so both behave as registered outputs.
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
